// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// Optional feature macro used by the scanner: KEYPAD_REPEAT_EN (auto-repeat).
package keypad_pkg;

  // Scanner FSM states
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  // Default geometry and timing
  localparam int DEFAULT_ROWS     = 4;
  localparam int DEFAULT_COLS     = 4;
  localparam int DEFAULT_SCAN_DIV = 1000;
  localparam int DEFAULT_DEBOUNCE = 3;

  // Index width for n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the row-major key code
  function automatic int key_width(input int rows, input int cols);
    return idx_width(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_col_ring.sv
// One-hot column strobe rotator. Loads column 0 on the first cycle after
// clear is released, then rotates one position per advance pulse.
module keypad_col_ring #(
  parameter int COLS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [COLS-1:0] columnas
);

  logic [COLS-1:0] ring_reg;
  logic [COLS-1:0] rotated;

  // Rotate left by one with wrap from the top column back to column 0
  for (genvar gi = 0; gi < COLS; gi++) begin : g_rot
    assign rotated[gi] = ring_reg[(gi + COLS - 1) % COLS];
  end

  // Strobe register: empty while cleared, seeded with column 0, then rotated
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ring_reg <= '0;
    end else if (ring_reg == '0) begin
      ring_reg <= COLS'(1);
    end else if (advance) begin
      ring_reg <= rotated;
    end
  end

  assign columnas = ring_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobing, row synchroniser, debounce FSM,
// release detection, multi-key rejection and a one-entry valid/ready event.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS         = DEFAULT_ROWS,
  parameter int COLS         = DEFAULT_COLS,
  parameter int SCAN_DIV     = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE     = DEFAULT_DEBOUNCE,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [ROWS-1:0]                     filas,
  output logic [COLS-1:0]                     columnas,
  output logic                                key_valid,
  input  logic                                key_ready,
  output logic [key_width(ROWS, COLS)-1:0]    key_code,
  output logic                                key_pressed,
  output logic                                multi_key,
  output logic                                overflow
);

  localparam int KW   = key_width(ROWS, COLS);
  localparam int RW   = idx_width(ROWS);
  localparam int CW   = idx_width(COLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int NW   = $clog2(ROWS + 1);
  localparam int CNTW = $clog2(DEBOUNCE + 1);

  // Elaboration-time parameter sanity checks
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8) begin : g_bad_geom
    $error("keypad_scanner: ROWS and COLS must be in 2..8");
  end
  if (SCAN_DIV < 4 || DEBOUNCE < 1) begin : g_bad_timing
    $error("keypad_scanner: SCAN_DIV must be >= 4 and DEBOUNCE >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_scanner: repeat intervals must be >= 1");
  end

  logic [ROWS-1:0] sync1_reg, sync2_reg;
  logic [DW-1:0]   dwell_reg;
  kp_state_t       state_reg, state_next;
  logic [CW-1:0]   col_idx_reg, col_next;
  logic [RW-1:0]   cand_row_reg, cand_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            key_pressed_reg, pressed_next;
  logic            multi_key_reg, multi_next;
  logic            key_valid_reg, overflow_reg;
  logic [KW-1:0]   key_code_reg;

  logic            active, tick, advance, emit, confirm, release_key;
  logic [NW-1:0]   row_count;
  logic [RW-1:0]   row_idx, emit_row;
  logic            one_row, row_bit;
  logic [KW-1:0]   emit_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);
  logic [RPW-1:0] rep_cnt_reg, rep_cnt_next;
  logic           rep_armed_reg, rep_armed_next;
  int             rep_limit;
`endif

  keypad_col_ring #(.COLS(COLS)) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (!enable),
    .advance  (advance),
    .columnas (columnas)
  );

  // Scanning is live only once a column is actually being strobed
  assign active = enable && (columnas != '0);
  assign tick   = active && (dwell_reg == DW'(SCAN_DIV - 1));

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= filas;
      sync2_reg <= sync1_reg;
    end
  end

  // Dwell counter: counts the cycles the current column has been driven
  always_ff @(posedge clk) begin
    if (reset || !active || tick) begin
      dwell_reg <= '0;
    end else begin
      dwell_reg <= dwell_reg + DW'(1);
    end
  end

  // Row population count and encoder (highest set row wins; only used when one is set)
  always_comb begin
    row_count = '0;
    row_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (sync2_reg[i]) begin
        row_count = row_count + NW'(1);
        row_idx   = RW'(i);
      end
    end
  end

  assign one_row   = (row_count == NW'(1));
  assign row_bit   = sync2_reg[cand_row_reg];
  assign emit_code = KW'(emit_row) * KW'(COLS) + KW'(col_idx_reg);

  // Next-state logic: evaluated once per dwell sample, forced home when disabled
  always_comb begin
    state_next   = state_reg;
    col_next     = col_idx_reg;
    cand_next    = cand_row_reg;
    cnt_next     = cnt_reg;
    pressed_next = key_pressed_reg;
    multi_next   = multi_key_reg;
    advance      = 1'b0;
    emit         = 1'b0;
    confirm      = 1'b0;
    release_key  = 1'b0;
    emit_row     = cand_row_reg;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next   = rep_cnt_reg;
    rep_armed_next = rep_armed_reg;
    rep_limit      = rep_armed_reg ? REPEAT_RATE : REPEAT_DELAY;
`endif
    if (!enable) begin
      state_next   = ST_SCAN;
      col_next     = '0;
      cnt_next     = '0;
      pressed_next = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_next   = '0;
      rep_armed_next = 1'b0;
`endif
    end else if (tick) begin
      multi_next = (row_count > NW'(1));
      unique case (state_reg)
        ST_SCAN: begin
          if (one_row) begin
            cand_next = row_idx;
            emit_row  = row_idx;
            if (DEBOUNCE == 1) begin
              confirm = 1'b1;
            end else begin
              cnt_next   = CNTW'(1);
              state_next = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (one_row && (row_idx == cand_row_reg)) begin
            if (cnt_reg == CNTW'(DEBOUNCE - 1)) begin
              confirm = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNTW'(1);
            end
          end else begin
            state_next = ST_SCAN;
            cnt_next   = '0;
            advance    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!row_bit) begin
            if (DEBOUNCE == 1) begin
              release_key = 1'b1;
            end else begin
              state_next = ST_RELEASE;
              cnt_next   = CNTW'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_next = '0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt_reg == RPW'(rep_limit - 1)) begin
              emit           = 1'b1;
              rep_cnt_next   = '0;
              rep_armed_next = 1'b1;
            end else begin
              rep_cnt_next = rep_cnt_reg + RPW'(1);
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (!row_bit) begin
            if (cnt_reg >= CNTW'(DEBOUNCE - 1)) begin
              release_key = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNTW'(1);
            end
          end else begin
            state_next = ST_HOLD;
            cnt_next   = '0;
          end
        end
        default: state_next = ST_SCAN;
      endcase

      if (confirm) begin
        emit         = 1'b1;
        pressed_next = 1'b1;
        state_next   = ST_HOLD;
        cnt_next     = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_next   = '0;
        rep_armed_next = 1'b0;
`endif
      end
      if (release_key) begin
        pressed_next = 1'b0;
        state_next   = ST_SCAN;
        cnt_next     = '0;
        advance      = 1'b1;
      end
      if (advance) begin
        col_next = (col_idx_reg == CW'(COLS - 1)) ? '0 : col_idx_reg + CW'(1);
      end
    end
  end

  // FSM state, column index, candidate and debounce counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_SCAN;
      col_idx_reg     <= '0;
      cand_row_reg    <= '0;
      cnt_reg         <= '0;
      key_pressed_reg <= 1'b0;
      multi_key_reg   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg     <= '0;
      rep_armed_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      col_idx_reg     <= col_next;
      cand_row_reg    <= cand_next;
      cnt_reg         <= cnt_next;
      key_pressed_reg <= pressed_next;
      multi_key_reg   <= multi_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg     <= rep_cnt_next;
      rep_armed_reg   <= rep_armed_next;
`endif
    end
  end

  // One-entry event register; a new event while full and not draining is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else if (emit) begin
      if (key_valid_reg && !key_ready) begin
        overflow_reg <= 1'b1;
      end else begin
        key_valid_reg <= 1'b1;
        key_code_reg  <= emit_code;
      end
    end else if (key_valid_reg && key_ready) begin
      key_valid_reg <= 1'b0;
    end
  end

  assign key_valid   = key_valid_reg;
  assign key_code    = key_code_reg;
  assign key_pressed = key_pressed_reg;
  assign multi_key   = multi_key_reg;
  assign overflow    = overflow_reg;

endmodule
